// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: the requester drives start, sub, a and b;
// the adder returns busy, done and the registered result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a ripple of full-adder
// cells, with a registered carry between digits and a start/busy/done handshake.
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    genvar gi;

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT (1 <= DIGIT <= WIDTH)");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] sa_reg;
    logic [WIDTH-1:0] sb_reg;
    logic [WIDTH-1:0] sr_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] dsum;
    logic [WIDTH-1:0] sr_next;

    // One digit of ripple: the only combinational path, DIGIT cells long.
    assign chain[0] = carry_reg;

    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_fa
            serial_adder_fa u_fa (
                .a  (sa_reg[gi]),
                .b  (sb_reg[gi]),
                .ci (chain[gi]),
                .s  (dsum[gi]),
                .co (chain[gi+1])
            );
        end
    endgenerate

    // Digit sums enter SR at the MSB end so after N steps the LSB digit sits at bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_sr_full
            assign sr_next = dsum;
        end else begin : g_sr_shift
            assign sr_next = {dsum, sr_reg[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            sr_reg    <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        // Subtraction is a + ~b + 1; the +1 rides in as the first carry.
                        sa_reg    <= bus.a;
                        sb_reg    <= bus.sub ? ~bus.b : bus.b;
                        carry_reg <= bus.sub;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    sa_reg    <= sa_reg >> DIGIT;
                    sb_reg    <= sb_reg >> DIGIT;
                    sr_reg    <= sr_next;
                    carry_reg <= chain[DIGIT];
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        // Results are registered on the way into DONE so they are valid with done.
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        sum_reg   <= sr_next;
                        cout_reg  <= chain[DIGIT];
                        ovf_reg   <= chain[DIGIT-1] ^ chain[DIGIT];
                        state_reg <= DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vector table and handshake sequences at WIDTH=8,
// plus randomized operations on several WIDTH/DIGIT configurations against an arithmetic model.
module tb_serial_adder;
    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_r = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus_a();
    serial_adder_if #(.WIDTH(8)) bus_b();

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    serial_adder #(.WIDTH(8), .DIGIT(4)) dut_b (.clk(clk), .rst(rst_a), .bus(bus_b));

    typedef struct packed {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Starts one operation on dut_a and counts edges (acceptance edge = 1) until done.
    task automatic run_a(input logic s, input logic [7:0] x, input logic [7:0] y,
                         output int lat, output int bcyc,
                         output logic [7:0] rs, output logic rc, output logic ro);
        @(negedge clk);
        bus_a.start = 1'b1;
        bus_a.sub   = s;
        bus_a.a     = x;
        bus_a.b     = y;
        lat  = 0;
        bcyc = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            bus_a.start = 1'b0;
            lat++;
            if (bus_a.busy) bcyc++;
            if (bus_a.done) break;
        end
        rs = bus_a.sum;
        rc = bus_a.cout;
        ro = bus_a.ovf;
    endtask

    function automatic int cfg_w(input int i);
        case (i)
            0, 1:    return 8;
            2, 3:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_d(input int i);
        case (i)
            0, 4:    return 1;
            1:       return 2;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    localparam int NCFG = 6;

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_rand
        localparam int W = cfg_w(gi);
        localparam int D = cfg_d(gi);
        localparam int N = W / D;

        logic fin = 1'b0;

        serial_adder_if #(.WIDTH(W)) rbus();
        serial_adder #(.WIDTH(W), .DIGIT(D)) dut (.clk(clk), .rst(rst_r), .bus(rbus));

        initial begin
            logic [W-1:0] x, y, esum;
            logic [W:0]   uadd;
            logic         s, ecout, eovf;
            longint       sx, sy, r;
            int           lat;
            rbus.start = 1'b0;
            rbus.sub   = 1'b0;
            rbus.a     = '0;
            rbus.b     = '0;
            wait (rst_r == 1'b0);
            for (int t = 0; t < 40; t++) begin
                x = W'($urandom);
                y = W'($urandom);
                s = 1'($urandom);
                if ($urandom_range(0, 7) == 0) x = {1'b1, {(W-1){1'b0}}};
                if ($urandom_range(0, 7) == 0) y = '1;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                @(negedge clk);
                rbus.start = 1'b1;
                rbus.sub   = s;
                rbus.a     = x;
                rbus.b     = y;
                lat = 0;
                for (int k = 0; k < N + 8; k++) begin
                    @(posedge clk);
                    #1;
                    rbus.start = 1'b0;
                    lat++;
                    if (rbus.done) break;
                end
                sx   = longint'($signed(x));
                sy   = longint'($signed(y));
                r    = s ? (sx - sy) : (sx + sy);
                eovf = (r > ((64'sd1 <<< (W-1)) - 64'sd1)) || (r < -(64'sd1 <<< (W-1)));
                esum = s ? (x - y) : (x + y);
                uadd = {1'b0, x} + {1'b0, y};
                ecout = s ? (x >= y) : uadd[W];
                $display("W=%0d D=%0d %h %s %h -> sum=%h cout=%b ovf=%b edges=%0d",
                         W, D, x, s ? "-" : "+", y, rbus.sum, rbus.cout, rbus.ovf, lat);
                check("rand_sum",     64'(rbus.sum),  64'(esum));
                check("rand_cout",    64'(rbus.cout), 64'(ecout));
                check("rand_ovf",     64'(rbus.ovf),  64'(eovf));
                check("rand_latency", 64'(lat),       64'(N + 1));
            end
            fin = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        int         lat, bcyc, dones;
        logic [7:0] rs;
        logic       rc, ro;

        vecs[0] = '{1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};

        bus_a.start = 1'b0; bus_a.sub = 1'b0; bus_a.a = '0; bus_a.b = '0;
        bus_b.start = 1'b0; bus_b.sub = 1'b0; bus_b.a = '0; bus_b.b = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus_a.busy), 64'd0);
        check("reset_done", 64'(bus_a.done), 64'd0);
        check("reset_sum",  64'(bus_a.sum),  64'd0);
        check("reset_cout", 64'(bus_a.cout), 64'd0);
        check("reset_ovf",  64'(bus_a.ovf),  64'd0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_r = 1'b0;

        // Directed vectors, WIDTH=8 DIGIT=1
        for (int i = 0; i < 7; i++) begin
            run_a(vecs[i].sub, vecs[i].a, vecs[i].b, lat, bcyc, rs, rc, ro);
            $display("vec %0d: %h %s %h -> sum=%h cout=%b ovf=%b edges=%0d busy=%0d",
                     i, vecs[i].a, vecs[i].sub ? "-" : "+", vecs[i].b, rs, rc, ro, lat, bcyc);
            check("vec_sum",     64'(rs),   64'(vecs[i].sum));
            check("vec_cout",    64'(rc),   64'(vecs[i].cout));
            check("vec_ovf",     64'(ro),   64'(vecs[i].ovf));
            check("vec_latency", 64'(lat),  64'd9);
            check("vec_busy",    64'(bcyc), 64'd8);
        end

        // DIGIT=4 with start held high through DONE: back-to-back operation
        @(negedge clk);
        bus_b.start = 1'b1; bus_b.sub = 1'b0; bus_b.a = 8'h9C; bus_b.b = 8'h64;
        lat = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus_b.done) break;
        end
        $display("d4 op1: 9c + 64 -> sum=%h cout=%b ovf=%b edges=%0d", bus_b.sum, bus_b.cout, bus_b.ovf, lat);
        check("d4_sum",     64'(bus_b.sum),  64'h00);
        check("d4_cout",    64'(bus_b.cout), 64'd1);
        check("d4_ovf",     64'(bus_b.ovf),  64'd0);
        check("d4_latency", 64'(lat),        64'd3);
        @(negedge clk);
        bus_b.a = 8'h10; bus_b.b = 8'h20;
        @(posedge clk);
        #1;
        bus_b.start = 1'b0;
        check("b2b_busy", 64'(bus_b.busy), 64'd1);
        check("b2b_done", 64'(bus_b.done), 64'd0);
        lat = 1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus_b.done) break;
        end
        $display("d4 op2: 10 + 20 -> sum=%h cout=%b ovf=%b edges=%0d", bus_b.sum, bus_b.cout, bus_b.ovf, lat);
        check("b2b_sum",     64'(bus_b.sum), 64'h30);
        check("b2b_latency", 64'(lat),       64'd3);

        // start pulsed during RUN must be ignored
        @(negedge clk);
        bus_a.start = 1'b1; bus_a.sub = 1'b0; bus_a.a = 8'h12; bus_a.b = 8'h34;
        lat = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            lat++;
            bus_a.start = (lat == 3);
            if (lat == 3) begin
                bus_a.a = 8'hFF;
                bus_a.b = 8'hFF;
            end
            if (bus_a.done) break;
        end
        $display("ignore: 12 + 34 -> sum=%h edges=%0d", bus_a.sum, lat);
        check("ignore_sum",     64'(bus_a.sum), 64'h46);
        check("ignore_latency", 64'(lat),       64'd9);
        @(posedge clk);
        #1;
        check("ignore_no_queue", 64'(bus_a.busy), 64'd0);

        // Reset during the third RUN cycle discards the operation
        @(negedge clk);
        bus_a.start = 1'b1; bus_a.a = 8'h0F; bus_a.b = 8'h0F;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrun_busy", 64'(bus_a.busy), 64'd1);
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        check("rst_busy", 64'(bus_a.busy), 64'd0);
        check("rst_done", 64'(bus_a.done), 64'd0);
        check("rst_sum",  64'(bus_a.sum),  64'd0);
        check("rst_cout", 64'(bus_a.cout), 64'd0);
        check("rst_ovf",  64'(bus_a.ovf),  64'd0);
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (bus_a.done) dones++;
        end
        $display("reset mid-run: done pulses afterwards=%0d", dones);
        check("rst_no_done", 64'(dones), 64'd0);

        wait (g_rand[0].fin && g_rand[1].fin && g_rand[2].fin &&
              g_rand[3].fin && g_rand[4].fin && g_rand[5].fin);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor built around the team's ripple full-adder cell. It processes DIGIT bits of two WIDTH-bit operands per clock, carrying between digits through a registered carry. It reports sum, carry-out and signed overflow with a start/busy/done handshake. It sits in the datapath wherever area matters more than latency, replacing a full WIDTH-bit combinational adder.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; ≥ 2.
- DIGIT, 1, bits added per cycle; 1 ≤ DIGIT ≤ WIDTH and WIDTH % DIGIT == 0 (elaboration error otherwise).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only when not busy.
- sub  in  1  0 = a + b, 1 = a − b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result (mod 2^WIDTH).
- cout  out  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.

## Operation
- N = WIDTH/DIGIT digit steps per operation.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch a into shift register SA.
  - Latch b (or ~b when sub=1) into SB.
  - Set carry register to sub, digit counter to 0, next state RUN.
  - start=0 → stay in IDLE.
- RUN, each cycle:
  - Add the low DIGIT bits of SA, SB and carry via a DIGIT-bit ripple of full-adder cells.
  - Shift the digit sum into result shift register SR from the MSB end.
  - Shift SA and SB right by DIGIT.
  - Update carry. Increment the counter.
  - On the final step (counter == N−1), also capture the carry into the MSB position (carry-in of bit WIDTH−1) for ovf, then go to DONE.
- DONE:
  - Load sum ← SR, cout ← final carry, ovf ← carry-into-MSB XOR carry-out-of-MSB.
  - Output registers are written only here; they hold until the next DONE or reset.
  - start=1 in DONE is accepted as in IDLE (back-to-back), and the next state is RUN. Otherwise the next state is IDLE.
- start asserted while in RUN is ignored; it is not queued.
- sub, a and b are don't-care except in the cycle start is accepted.

## Timing
- Reset (rst=1 at an edge) from any state, including mid-RUN:
  - State goes to IDLE; any operation in progress is discarded.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Counter, carry and shift registers are cleared.
- busy = 1 exactly while in RUN. It rises in the cycle after the edge that accepts start.
- done = 1 exactly while in DONE, for one cycle per operation.
- Latency: start accepted at edge E → busy high for cycles after E..E+N−1 → done high in the cycle after edge E+N. That is N+1 edges from acceptance to done observed, with sum/cout/ovf valid in that same cycle.
- Throughput with back-to-back start held in DONE: one result per N+1 cycles.
- The critical path is a DIGIT-bit ripple, independent of WIDTH.

## Test plan
- WIDTH=8, DIGIT=1: a=0x35, b=0x4A, sub=0 → done 9 edges after acceptance; sum=0x7F, cout=0, ovf=0; busy high exactly 8 cycles.
- WIDTH=8, DIGIT=1:
  - 0x7F+0x01 → sum=0x80, cout=0, ovf=1.
  - 0xFF+0x01 → sum=0x00, cout=1, ovf=0.
- WIDTH=8, DIGIT=1, sub=1:
  - 0x05−0x07 → sum=0xFE, cout=0, ovf=0.
  - 0x80−0x01 → sum=0x7F, cout=1, ovf=1.
- WIDTH=8, DIGIT=4: 0x9C+0x64 → sum=0x00, cout=1, ovf=0, done 3 edges after acceptance; start held through DONE → second operation starts with no IDLE gap.
- Start 0x12+0x34, assert start with a=0xFF during RUN → ignored; result is 0x46. Then start a new operation, assert rst at its 3rd RUN cycle → next cycle busy=0, done=0, sum=0, cout=0, ovf=0, and no done pulse follows.
- Random regression, WIDTH∈{8,16,32}, DIGIT∈{1,2,4,8}, both modes: sum/cout/ovf match the reference model a±b, with done exactly N+1 edges after each accepted start.
